// File: rtl/nf_10g_if_reg_arbiter.sv
// Round-robin arbiter sharing the synchronized register-access port between requesters.
// One access in flight; enforces a chip-select gap and times out silent accesses.
module nf_10g_if_reg_arbiter #(
   parameter int unsigned C_NUM_MASTERS      = 2,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_TIMEOUT          = 64
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [C_NUM_MASTERS-1:0]                      req_cs,
   input  logic [C_NUM_MASTERS-1:0]                      req_rnw,
   input  logic [C_NUM_MASTERS*C_S_AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [C_NUM_MASTERS*C_S_AXI_DATA_WIDTH-1:0]   req_data,
   input  logic [C_NUM_MASTERS*(C_S_AXI_DATA_WIDTH/8)-1:0] req_be,
   output logic [C_NUM_MASTERS-1:0]                      req_rdack,
   output logic [C_NUM_MASTERS-1:0]                      req_wrack,
   output logic                                          req_error,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                 req_rdata,
   output logic                                          bus2ip_cs_sync,
   output logic                                          bus2ip_rnw_sync,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]                 bus2ip_addr_sync,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                 bus2ip_data_sync,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]               bus2ip_be_sync,
   input  logic                                          ip2bus_rdack_sync,
   input  logic                                          ip2bus_wrack_sync,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                 ip2bus_data_sync,
   input  logic                                          ip2bus_error_sync
);

   localparam int unsigned N  = C_NUM_MASTERS;
   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
   // The grant edge clears the counter, so expiry lands C_TIMEOUT+1 cycles after the grant.
   localparam logic [7:0]  CNT_EXPIRE = 8'(C_TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [GW-1:0]  last_grant;
   logic [GW-1:0]  owner;
   logic [GW-1:0]  winner;
   logic [GW-1:0]  cand;
   logic [7:0]     cnt;
   logic           ack_ok;
   logic           grant;
   logic           done;
   logic           expire;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and completion decode
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done      = 1'b0;
      expire    = 1'b0;
      ack_ok    = bus2ip_rnw_sync ? ip2bus_rdack_sync : ip2bus_wrack_sync;
      case (state)
         IDLE: begin
            if (|req_cs) begin
               grant     = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (ack_ok) begin
               done      = 1'b1;
               state_nxt = GAP;
            end else if (cnt == CNT_EXPIRE) begin
               done      = 1'b1;
               expire    = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Round-robin pick; scanning downward lets the nearest requester after last_grant win
   always_comb begin
      winner = last_grant;
      cand   = last_grant;
      for (int unsigned k = N; k > 0; k--) begin
         cand = GW'((32'(last_grant) + k) % N);
         if (req_cs[cand]) winner = cand;
      end
   end

   // Registered bus-side and requester-side outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant       <= GW'(N - 1);
         owner            <= '0;
         cnt              <= '0;
         req_rdack        <= '0;
         req_wrack        <= '0;
         req_error        <= 1'b0;
         req_rdata        <= '0;
         bus2ip_cs_sync   <= 1'b0;
         bus2ip_rnw_sync  <= 1'b1;
         bus2ip_addr_sync <= '0;
         bus2ip_data_sync <= '0;
         bus2ip_be_sync   <= '0;
      end else begin
         req_rdack <= '0;
         req_wrack <= '0;
         req_error <= 1'b0;
         if (grant) begin
            owner            <= winner;
            cnt              <= '0;
            bus2ip_cs_sync   <= 1'b1;
            bus2ip_rnw_sync  <= req_rnw[winner];
            bus2ip_addr_sync <= req_addr[32'(winner)*AW +: AW];
            bus2ip_data_sync <= req_data[32'(winner)*DW +: DW];
            bus2ip_be_sync   <= req_be[32'(winner)*BW +: BW];
         end
         if (state == BUSY && !done) cnt <= cnt + 8'd1;
         if (done) begin
            bus2ip_cs_sync <= 1'b0;
            last_grant     <= owner;
            if (bus2ip_rnw_sync) req_rdack[owner] <= 1'b1;
            else                 req_wrack[owner] <= 1'b1;
            req_error <= expire ? 1'b1 : ip2bus_error_sync;
            if (expire)               req_rdata <= DW'(32'hDEADBEEF);
            else if (bus2ip_rnw_sync) req_rdata <= ip2bus_data_sync;
         end
      end
   end

endmodule

// File: tb/tb_nf_10g_if_reg_arbiter.sv
// Directed bench for nf_10g_if_reg_arbiter with a behavioural register-block stub.
module tb_nf_10g_if_reg_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_cs, req_rnw;
   logic [N*AW-1:0]   req_addr;
   logic [N*32-1:0]   req_data;
   logic [N*4-1:0]    req_be;
   logic [N-1:0]      req_rdack, req_wrack;
   logic              req_error;
   logic [31:0]       req_rdata;
   logic              bus2ip_cs_sync, bus2ip_rnw_sync;
   logic [AW-1:0]     bus2ip_addr_sync;
   logic [31:0]       bus2ip_data_sync;
   logic [3:0]        bus2ip_be_sync;
   logic              ip2bus_rdack_sync = 1'b0;
   logic              ip2bus_wrack_sync = 1'b0;
   logic [31:0]       ip2bus_data_sync;
   logic              ip2bus_error_sync;

   int                n_checks = 0;
   int                n_errors = 0;

   // Stub controls: ack after stub_delay cycles of cs; optional wrong-type ack at stub_wrong
   int                stub_cnt   = 0;
   bit                stub_en    = 1'b1;
   int                stub_delay = 1;
   int                stub_wrong = 0;
   logic [31:0]       stub_data  = '0;

   nf_10g_if_reg_arbiter #(
      .C_NUM_MASTERS(N), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(32), .C_TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_cs(req_cs), .req_rnw(req_rnw), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
      .req_rdack(req_rdack), .req_wrack(req_wrack), .req_error(req_error), .req_rdata(req_rdata),
      .bus2ip_cs_sync(bus2ip_cs_sync), .bus2ip_rnw_sync(bus2ip_rnw_sync),
      .bus2ip_addr_sync(bus2ip_addr_sync), .bus2ip_data_sync(bus2ip_data_sync),
      .bus2ip_be_sync(bus2ip_be_sync),
      .ip2bus_rdack_sync(ip2bus_rdack_sync), .ip2bus_wrack_sync(ip2bus_wrack_sync),
      .ip2bus_data_sync(ip2bus_data_sync), .ip2bus_error_sync(ip2bus_error_sync)
   );

   always #5 clk = ~clk;

   assign ip2bus_data_sync  = stub_data;
   assign ip2bus_error_sync = 1'b0;

   always @(posedge clk) begin
      ip2bus_rdack_sync <= 1'b0;
      ip2bus_wrack_sync <= 1'b0;
      if (!bus2ip_cs_sync) stub_cnt <= 0;
      else begin
         stub_cnt <= stub_cnt + 1;
         if (stub_en && stub_cnt + 1 == stub_delay) begin
            if (bus2ip_rnw_sync) ip2bus_rdack_sync <= 1'b1;
            else                 ip2bus_wrack_sync <= 1'b1;
         end
         if (stub_cnt + 1 == stub_wrong) begin
            if (bus2ip_rnw_sync) ip2bus_wrack_sync <= 1'b1;
            else                 ip2bus_rdack_sync <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic cs, input logic rnw, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
      req_cs[i]            = cs;
      req_rnw[i]           = rnw;
      req_addr[i*AW +: AW] = addr;
      req_data[i*32 +: 32] = data;
      req_be[i*4 +: 4]     = be;
   endtask

   initial begin
      logic [1:0] exp_ack;
      reset    = 1'b1;
      req_cs   = '0;
      req_rnw  = '0;
      req_addr = '0;
      req_data = '0;
      req_be   = '0;
      repeat (2) tick();
      check("rst_cs",    64'(bus2ip_cs_sync),   64'd0);
      check("rst_rnw",   64'(bus2ip_rnw_sync),  64'd1);
      check("rst_addr",  64'(bus2ip_addr_sync), 64'd0);
      check("rst_data",  64'(bus2ip_data_sync), 64'd0);
      check("rst_be",    64'(bus2ip_be_sync),   64'd0);
      check("rst_acks",  64'({req_rdack, req_wrack}), 64'd0);
      check("rst_err",   64'(req_error),        64'd0);
      check("rst_rdata", 64'(req_rdata),        64'd0);
      reset = 1'b0;

      // Single read by master 0
      stub_data = 32'h0000ABCD;
      set_req(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
      tick();
      check("rd_cs",    64'(bus2ip_cs_sync),   64'd1);
      check("rd_rnw",   64'(bus2ip_rnw_sync),  64'd1);
      check("rd_addr",  64'(bus2ip_addr_sync), 64'd0);
      tick();
      check("rd_noack", 64'({req_rdack, req_wrack}), 64'd0);
      check("rd_cs1",   64'(bus2ip_cs_sync),   64'd1);
      tick();
      check("rd_rdack", 64'(req_rdack), 64'b01);
      check("rd_wrack", 64'(req_wrack), 64'b00);
      check("rd_rdata", 64'(req_rdata), 64'h0000ABCD);
      check("rd_err",   64'(req_error), 64'd0);
      check("rd_cslo",  64'(bus2ip_cs_sync), 64'd0);
      req_cs[0] = 1'b0;
      tick();
      check("rd_pulse", 64'(req_rdack), 64'b00);
      check("rd_gap",   64'(bus2ip_cs_sync), 64'd0);
      tick();
      check("rd_idle",  64'(bus2ip_cs_sync), 64'd0);

      // Contention: both masters write 0x8 continuously after a reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h8, 32'h11110000, 4'hF);
      set_req(1, 1'b1, 1'b0, 32'h8, 32'h22221111, 4'h3);
      for (int c = 0; c < 16; c++) begin
         tick();
         exp_ack = (c % 4 == 2) ? (((c / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         check($sformatf("cn_cs%0d", c),    64'(bus2ip_cs_sync), 64'((c % 4) < 2));
         check($sformatf("cn_wrack%0d", c), 64'(req_wrack), 64'(exp_ack));
         check($sformatf("cn_rdack%0d", c), 64'(req_rdack), 64'd0);
         if (c % 4 == 0) begin
            check($sformatf("cn_data%0d", c), 64'(bus2ip_data_sync),
                  ((c / 4) % 2 == 1) ? 64'h22221111 : 64'h11110000);
            check($sformatf("cn_be%0d", c),   64'(bus2ip_be_sync),
                  ((c / 4) % 2 == 1) ? 64'h3 : 64'hF);
            check($sformatf("cn_addr%0d", c), 64'(bus2ip_addr_sync), 64'h8);
            check($sformatf("cn_rnw%0d", c),  64'(bus2ip_rnw_sync), 64'd0);
         end
      end
      req_cs = '0;
      tick();

      // Timeout: master 1 reads, stub silent
      stub_en = 1'b0;
      set_req(1, 1'b1, 1'b1, 32'h40, 32'h0, 4'hF);
      tick();
      check("to_cs",   64'(bus2ip_cs_sync),   64'd1);
      check("to_addr", 64'(bus2ip_addr_sync), 64'h40);
      for (int c = 1; c <= 9; c++) begin
         tick();
         check($sformatf("to_rdack%0d", c), 64'(req_rdack), (c == 9) ? 64'b10 : 64'b00);
         check($sformatf("to_cs%0d", c),    64'(bus2ip_cs_sync), (c == 9) ? 64'd0 : 64'd1);
         if (c == 9) begin
            check("to_err",   64'(req_error), 64'd1);
            check("to_rdata", 64'(req_rdata), 64'hDEADBEEF);
         end
      end
      req_cs[1] = 1'b0;
      tick();

      // Wrong-type ack: rdack during a write is ignored, wrack completes
      stub_en    = 1'b1;
      stub_delay = 3;
      stub_wrong = 1;
      set_req(1, 1'b1, 1'b0, 32'hC, 32'hCAFEF00D, 4'hF);
      tick();
      check("wt_data", 64'(bus2ip_data_sync), 64'hCAFEF00D);
      for (int c = 1; c <= 4; c++) begin
         tick();
         check($sformatf("wt_wrack%0d", c), 64'(req_wrack), (c == 4) ? 64'b10 : 64'b00);
         check($sformatf("wt_rdack%0d", c), 64'(req_rdack), 64'b00);
         check($sformatf("wt_cs%0d", c),    64'(bus2ip_cs_sync), (c == 4) ? 64'd0 : 64'd1);
      end
      req_cs[1]  = 1'b0;
      stub_wrong = 0;
      tick();

      // Ack arrives on the expiry cycle: normal completion wins
      stub_delay = 8;
      stub_data  = 32'h12345678;
      set_req(0, 1'b1, 1'b1, 32'h4, 32'h0, 4'hF);
      tick();
      check("co_addr", 64'(bus2ip_addr_sync), 64'h4);
      for (int c = 1; c <= 9; c++) begin
         tick();
         check($sformatf("co_rdack%0d", c), 64'(req_rdack), (c == 9) ? 64'b01 : 64'b00);
         if (c == 9) begin
            check("co_err",   64'(req_error), 64'd0);
            check("co_rdata", 64'(req_rdata), 64'h12345678);
         end
      end
      req_cs[0] = 1'b0;
      tick();

      // Reset mid-BUSY: master 1 wins first (last grant 0), reset restores master 0 priority
      stub_en = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h100, 32'h0, 4'hF);
      set_req(1, 1'b1, 1'b1, 32'h200, 32'h0, 4'hF);
      tick();
      check("rb_addr1", 64'(bus2ip_addr_sync), 64'h200);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("rb_cs",   64'(bus2ip_cs_sync), 64'd0);
      check("rb_acks", 64'({req_rdack, req_wrack}), 64'd0);
      check("rb_addr", 64'(bus2ip_addr_sync), 64'd0);
      check("rb_rnw",  64'(bus2ip_rnw_sync), 64'd1);
      reset      = 1'b0;
      stub_en    = 1'b1;
      stub_delay = 1;
      stub_data  = 32'h5A5A0001;
      tick();
      check("rb_cs2",   64'(bus2ip_cs_sync), 64'd1);
      check("rb_addr0", 64'(bus2ip_addr_sync), 64'h100);
      tick();
      check("rb_noack", 64'({req_rdack, req_wrack}), 64'd0);
      tick();
      check("rb_rdack", 64'(req_rdack), 64'b01);
      check("rb_rdata", 64'(req_rdata), 64'h5A5A0001);
      req_cs = '0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
